fir_sample_reader: RTL and testbench

//  Delay-line read side of the FIR datapath: stores the last TAPS input samples in a

---
 rtl/fir_sample_reader.sv | 118 +++++++++++
 tb/tb_fir_sample_reader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_reader.sv
// fir_sample_reader: circular delay line holding the last TAPS samples. Each
// accepted sample triggers a burst of TAPS beats, newest first, so that beat k
// carries x[n-k] for pairing with coefficient h[k].
// Optional feature: define FIR_READER_CLEAR_EN to add a synchronous `clear`
// input that wipes the history and returns to IDLE (rst still wins).
module fir_sample_reader #(
  parameter  int DATA_W = 16,
  parameter  int TAPS   = 8,
  localparam int ADDR_W = $clog2(TAPS)
) (
  input  logic              clk,
  input  logic              rst,
`ifdef FIR_READER_CLEAR_EN
  input  logic              clear,
`endif
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TAPS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  typedef enum logic {
    IDLE,
    READ
  } state_t;

  state_t              state_q;
  logic [DATA_W-1:0]   mem_q [TAPS];
  logic [ADDR_W-1:0]   wr_ptr_q, rd_ptr_q, idx_q;
  logic [ADDR_W-1:0]   wr_ptr_d, rd_ptr_d, idx_d;
  logic [DATA_W-1:0]   out_data_q;
  logic                in_ready_q, out_valid_q, out_last_q, busy_q;
  logic                flush;

  // rst and clear have identical effect, so they share one flush path
`ifdef FIR_READER_CLEAR_EN
  assign flush = rst | clear;
`else
  assign flush = rst;
`endif

  // Pointer arithmetic, wrapping modulo TAPS (valid for non-power-of-2 depths)
  always_comb begin
    wr_ptr_d = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ONE;
    rd_ptr_d = (rd_ptr_q == '0) ? LAST_IDX : rd_ptr_q - ONE;
    idx_d    = idx_q + ONE;
  end

  // Control FSM, delay-line storage and registered stream outputs
  always_ff @(posedge clk) begin
    if (flush) begin
      state_q     <= IDLE;
      for (int unsigned i = 0; i < TAPS; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      idx_q       <= '0;
      out_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            mem_q[wr_ptr_q] <= in_data;
            rd_ptr_q        <= wr_ptr_q;
            wr_ptr_q        <= wr_ptr_d;
            idx_q           <= '0;
            // the new sample is beat 0; forward it rather than re-reading mem
            out_data_q      <= in_data;
            out_last_q      <= 1'b0;
            out_valid_q     <= 1'b1;
            in_ready_q      <= 1'b0;
            busy_q          <= 1'b1;
            state_q         <= READ;
          end
        end
        READ: begin
          if (out_ready) begin
            if (out_last_q) begin
              state_q     <= IDLE;
              idx_q       <= '0;
              out_data_q  <= '0;
              out_last_q  <= 1'b0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
              busy_q      <= 1'b0;
            end else begin
              // prefetch the next beat so outputs stay registered
              rd_ptr_q   <= rd_ptr_d;
              idx_q      <= idx_d;
              out_data_q <= mem_q[rd_ptr_d];
              out_last_q <= (idx_d == LAST_IDX);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_idx   = idx_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fir_sample_reader.sv
// Scoreboard bench for fir_sample_reader with TAPS=4, DATA_W=8. A shift-register
// history model predicts every burst; beats are compared as they are handshaken.
module tb_fir_sample_reader;

  localparam int DW = 8;
  localparam int NT = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear_s = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic [1:0]    out_idx;
  logic          out_last;
  logic          busy;

  fir_sample_reader #(.DATA_W(DW), .TAPS(NT)) dut (
    .clk      (clk),
    .rst      (rst),
`ifdef FIR_READER_CLEAR_EN
    .clear    (clear_s),
`endif
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [1:0]    idx;
    logic          last;
  } beat_t;

  beat_t         exp_q[$];
  logic [DW-1:0] hist [NT];
  int            n_checks = 0;
  int            n_pass   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic model_flush();
    exp_q.delete();
    for (int k = 0; k < NT; k++) hist[k] = '0;
  endtask

  // Offer a sample (held through any busy period); predict its burst on acceptance.
  // Called and returns at posedge+1.
  task automatic push(input logic [DW-1:0] x);
    int n = 0;
    beat_t b;
    in_valid = 1'b1;
    in_data  = x;
    while (!in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = x;
    for (int k = 0; k < NT; k++) begin
      b.d    = hist[k];
      b.idx  = 2'(k);
      b.last = (k == NT - 1);
      exp_q.push_back(b);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || !in_ready) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_done", int'(exp_q.size() == 0 && in_ready), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_flush();
  endtask

  // Compare each handshaken beat against the scoreboard
  always @(negedge clk) begin
    if (!rst && !clear_s && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_beat", 1, 0);
      end else begin
        beat_t e;
        e = exp_q.pop_front();
        check("beat_data", int'(out_data), int'(e.d));
        check("beat_idx",  int'(out_idx),  int'(e.idx));
        check("beat_last", int'(out_last), int'(e.last));
        check("beat_busy", int'(busy), 1);
        check("beat_in_ready", int'(in_ready), 0);
      end
    end
  end

  initial begin
    int n;
    model_flush();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // 1: reset state
    check("rst_in_ready",  int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_busy",      int'(busy), 0);
    check("rst_out_data",  int'(out_data), 0);
    check("rst_out_idx",   int'(out_idx), 0);
    check("rst_out_last",  int'(out_last), 0);

    // 2: single push into empty history
    push(8'h11);
    drain();
    check("idle_in_ready", int'(in_ready), 1);
    check("idle_out_valid", int'(out_valid), 0);

    // 3: back-to-back pushes exercising pointer wrap
    for (int v = 1; v <= 5; v++) push(8'(v));
    drain();

    // 4: backpressure at idx 1 of burst 4,3,2,1; in_valid ignored while stalled
    do_reset();
    for (int v = 1; v <= 4; v++) push(8'(v));
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hEE;
    repeat (3) begin
      @(posedge clk); #1;
      check("stall_data", int'(out_data), 3);
      check("stall_idx",  int'(out_idx), 1);
      check("stall_last", int'(out_last), 0);
      check("stall_in_ready", int'(in_ready), 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // 5: reset mid-burst, history lost
    push(8'h21);
    push(8'h22);
    n = 0;
    while (out_idx != 2'd2 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("reach_idx2", int'(out_idx), 2);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    model_flush();
    check("mid_rst_out_valid", int'(out_valid), 0);
    check("mid_rst_in_ready",  int'(in_ready), 1);
    check("mid_rst_out_idx",   int'(out_idx), 0);
    check("mid_rst_out_data",  int'(out_data), 0);
    push(8'h09);
    drain();

`ifdef FIR_READER_CLEAR_EN
    // 6: clear mid-burst with a sample offered; sample must not be taken
    push(8'h31);
    clear_s  = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h77;
    @(posedge clk); #1;
    clear_s  = 1'b0;
    in_valid = 1'b0;
    model_flush();
    check("clr_out_valid", int'(out_valid), 0);
    check("clr_in_ready",  int'(in_ready), 1);
    check("clr_busy",      int'(busy), 0);
    // clear in IDLE with a sample offered
    clear_s  = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    clear_s  = 1'b0;
    in_valid = 1'b0;
    check("clr_idle_out_valid", int'(out_valid), 0);
    push(8'h07);
    drain();
`endif

    repeat (3) @(posedge clk);
    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
